// File: rtl/ifetch_buf.sv
// ifetch_buf: instruction fetch stage in front of the decoder.
//
// Keeps the fetch PC, issues one word read per cycle to instruction memory
// and holds the returned words in a small in-order slot ring. The oldest
// returned word is offered to decode with its PC and pre-sliced fields.
// A redirect flushes everything and restarts fetch at the new PC. Responses
// to reads that were in flight at the redirect are counted and then
// discarded as they arrive.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active-low
//   imem_req     read request, accepted in the cycle it is high
//   imem_addr    word-aligned read address
//   imem_rvalid  read data valid (in-order responses, latency >= 1)
//   imem_rdata   returned instruction word
//   redirect     one-cycle pulse from branch/jump resolution
//   redirect_pc  new fetch PC (bits [1:0] forced to zero)
//   id_ready     decoder takes the head entry this cycle
//   id_valid     head entry holds a returned instruction
//   id_inst      head instruction, NOP when !id_valid
//   id_pc        PC of the head instruction
//   opcode       id_inst[6:2]
//   func3        id_inst[14:12]
//   func7        id_inst[31:25]
//   id_illegal   head instruction is not a 32-bit encoding
//
// Slots are used as a ring: from head to fill they are FULL, from fill to
// tail they are PENDING, the rest are FREE. A slot released by a pop only
// becomes issuable in the following cycle, so with a 1-cycle memory a
// 2-slot ring delivers two instructions every three cycles; gapless
// delivery needs at least three slots.
module ifetch_buf #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_inst,
  output logic [XLEN-1:0] id_pc,
  output logic [4:0]      opcode,
  output logic [2:0]      func3,
  output logic [6:0]      func7,
  output logic            id_illegal
);

  localparam int              PTR_W  = $clog2(DEPTH);
  localparam int              DROP_W = $clog2(DEPTH * 2) + 1;
  localparam logic [XLEN-1:0] NOP    = XLEN'(32'h0000_0013);

  typedef enum logic [1:0] {
    FREE    = 2'b00,
    PENDING = 2'b01,
    FULL    = 2'b10
  } slot_e;

  slot_e             slot_st   [DEPTH];
  logic [XLEN-1:0]   slot_pc   [DEPTH];
  logic [XLEN-1:0]   slot_inst [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  fill;
  logic [PTR_W-1:0]  tail;
  logic [XLEN-1:0]   fetch_pc;
  logic [DROP_W-1:0] drop_cnt;

  logic              issue;
  logic              fill_ok;
  logic              drop_one;
  logic              pop;
  logic              head_full;
  logic [DROP_W-1:0] pend_cnt;

  // Responses still owed by memory after a flush: the ones already being
  // discarded, plus every PENDING slot, minus whichever response is
  // consumed in the redirect cycle itself.
  function automatic logic [DROP_W-1:0] redirect_drop(
    input logic [DROP_W-1:0] cnt,
    input logic [DROP_W-1:0] pend,
    input logic              consumed
  );
    return cnt + pend - DROP_W'(consumed);
  endfunction

  // The tail slot is free exactly when any slot is free, since occupied
  // slots are contiguous from head. rst gates the request so that it drops
  // the moment reset is asserted.
  assign issue     = rst & ~redirect & (slot_st[tail] == FREE);
  assign fill_ok   = imem_rvalid & (drop_cnt == '0) & (slot_st[fill] == PENDING);
  assign drop_one  = imem_rvalid & (drop_cnt != '0);
  assign head_full = (slot_st[head] == FULL);
  assign pop       = head_full & id_ready & ~redirect;

  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_st[i] == PENDING) pend_cnt = pend_cnt + DROP_W'(1);
    end
  end

  // ---- fetch / response / pop control state ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) slot_st[i] <= FREE;
      head     <= '0;
      fill     <= '0;
      tail     <= '0;
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
    end else if (redirect) begin
      for (int i = 0; i < DEPTH; i++) slot_st[i] <= FREE;
      head     <= '0;
      fill     <= '0;
      tail     <= '0;
      fetch_pc <= redirect_pc & ~XLEN'(3);
      drop_cnt <= redirect_drop(drop_cnt, pend_cnt, fill_ok | drop_one);
    end else begin
      // issue, fill and pop always touch three different slots
      if (issue) begin
        slot_st[tail] <= PENDING;
        tail          <= tail + PTR_W'(1);
        fetch_pc      <= fetch_pc + XLEN'(4);
      end
      if (fill_ok) begin
        slot_st[fill] <= FULL;
        fill          <= fill + PTR_W'(1);
      end
      if (drop_one) drop_cnt <= drop_cnt - DROP_W'(1);
      if (pop) begin
        slot_st[head] <= FREE;
        head          <= head + PTR_W'(1);
      end
    end
  end

  // ---- slot payload (qualified by slot_st, so left unreset) ----
  always_ff @(posedge clk) begin
    if (issue)   slot_pc[tail]   <= fetch_pc;
    if (fill_ok) slot_inst[fill] <= imem_rdata;
  end

  // ---- decode-facing head view ----
  assign imem_req   = issue;
  assign imem_addr  = fetch_pc;
  assign id_valid   = head_full;
  assign id_inst    = head_full ? slot_inst[head] : NOP;
  // With nothing outstanding the next instruction to appear is fetch_pc.
  assign id_pc      = (slot_st[head] != FREE) ? slot_pc[head] : fetch_pc;
  assign opcode     = id_inst[6:2];
  assign func3      = id_inst[14:12];
  assign func7      = id_inst[31:25];
  assign id_illegal = head_full & (id_inst[1:0] != 2'b11);

endmodule
